// File: rtl/mysys_ram_arbiter.sv
// Two-requester arbiter in front of the single-port 4096x32 on-chip RAM.
// One grant per clock; read data returns one cycle later, steered to its owner.
module mysys_ram_arbiter #(
  parameter int FIXED_PRIORITY = 0,
  parameter int STARVE_LIMIT   = 16
) (
  input  logic        clk,
  input  logic        reset,

  input  logic [11:0] m0_address,
  input  logic [3:0]  m0_byteenable,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  output logic        m0_readdatavalid,

  input  logic [11:0] m1_address,
  input  logic [3:0]  m1_byteenable,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic        m1_readdatavalid,

  output logic [11:0] ram_address,
  output logic [3:0]  ram_byteenable,
  output logic        ram_chipselect,
  output logic        ram_write,
  output logic [31:0] ram_writedata,
  output logic        ram_clken,
  output logic        ram_reset_req,
  input  logic [31:0] ram_readdata
);

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_LIMIT);

  logic       req0, req1;
  logic       gnt0, gnt1;
  logic       last_grant;
  logic [7:0] starve_cnt;
  logic       rd_pending;
  logic       rd_owner;
  logic       rd_grant;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Grants are suppressed during reset so nothing reaches the RAM.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (req0 && req1) begin
        if (FIXED_PRIORITY != 0) begin
          if (starve_cnt >= STARVE_LIM) gnt1 = 1'b1;
          else                          gnt0 = 1'b1;
        end else if (last_grant) begin
          gnt0 = 1'b1;
        end else begin
          gnt1 = 1'b1;
        end
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  assign m0_waitrequest = req0 & ~gnt0;
  assign m1_waitrequest = req1 & ~gnt1;

  always_comb begin
    ram_address    = m0_address;
    ram_byteenable = m0_byteenable;
    ram_writedata  = m0_writedata;
    ram_write      = gnt0 & m0_write;
    if (gnt1) begin
      ram_address    = m1_address;
      ram_byteenable = m1_byteenable;
      ram_writedata  = m1_writedata;
      ram_write      = m1_write;
    end
  end

  assign ram_chipselect = gnt0 | gnt1;
  assign ram_clken      = 1'b1;
  assign ram_reset_req  = 1'b0;

  // Read+write together counts as a write, so it never produces a return.
  assign rd_grant = (gnt0 & m0_read & ~m0_write) | (gnt1 & m1_read & ~m1_write);

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
      starve_cnt <= 8'd0;
      rd_pending <= 1'b0;
      rd_owner   <= 1'b0;
    end else begin
      if (gnt0 | gnt1) last_grant <= gnt1;
      if (!req1 || gnt1)            starve_cnt <= 8'd0;
      else if (starve_cnt != 8'hFF) starve_cnt <= starve_cnt + 8'd1;
      rd_pending <= rd_grant;
      rd_owner   <= gnt1;
    end
  end

  // Gated by reset so a read issued just before reset never returns.
  assign m0_readdatavalid = rd_pending & ~rd_owner & ~reset;
  assign m1_readdatavalid = rd_pending &  rd_owner & ~reset;
  assign m0_readdata      = m0_readdatavalid ? ram_readdata : 32'd0;
  assign m1_readdata      = m1_readdatavalid ? ram_readdata : 32'd0;

endmodule

// File: tb/tb_mysys_ram_arbiter.sv
// Directed bench for mysys_ram_arbiter: one round-robin and one fixed-priority
// instance, each with its own behavioural synchronous RAM.
module tb_mysys_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;

  logic        rr_m0_waitrequest, rr_m1_waitrequest, rr_m0_readdatavalid, rr_m1_readdatavalid;
  logic [31:0] rr_m0_readdata, rr_m1_readdata, rr_ram_writedata, rr_ram_readdata;
  logic [11:0] rr_ram_address;
  logic [3:0]  rr_ram_byteenable;
  logic        rr_ram_chipselect, rr_ram_write, rr_ram_clken, rr_ram_reset_req;

  logic        fx_m0_waitrequest, fx_m1_waitrequest, fx_m0_readdatavalid, fx_m1_readdatavalid;
  logic [31:0] fx_m0_readdata, fx_m1_readdata, fx_ram_writedata, fx_ram_readdata;
  logic [11:0] fx_ram_address;
  logic [3:0]  fx_ram_byteenable;
  logic        fx_ram_chipselect, fx_ram_write, fx_ram_clken, fx_ram_reset_req;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mysys_ram_arbiter u_rr (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(rr_m0_waitrequest),
    .m0_readdata(rr_m0_readdata), .m0_readdatavalid(rr_m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(rr_m1_waitrequest),
    .m1_readdata(rr_m1_readdata), .m1_readdatavalid(rr_m1_readdatavalid),
    .ram_address(rr_ram_address), .ram_byteenable(rr_ram_byteenable),
    .ram_chipselect(rr_ram_chipselect), .ram_write(rr_ram_write),
    .ram_writedata(rr_ram_writedata), .ram_clken(rr_ram_clken),
    .ram_reset_req(rr_ram_reset_req), .ram_readdata(rr_ram_readdata)
  );

  mysys_ram_arbiter #(.FIXED_PRIORITY(1), .STARVE_LIMIT(4)) u_fx (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(fx_m0_waitrequest),
    .m0_readdata(fx_m0_readdata), .m0_readdatavalid(fx_m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(fx_m1_waitrequest),
    .m1_readdata(fx_m1_readdata), .m1_readdatavalid(fx_m1_readdatavalid),
    .ram_address(fx_ram_address), .ram_byteenable(fx_ram_byteenable),
    .ram_chipselect(fx_ram_chipselect), .ram_write(fx_ram_write),
    .ram_writedata(fx_ram_writedata), .ram_clken(fx_ram_clken),
    .ram_reset_req(fx_ram_reset_req), .ram_readdata(fx_ram_readdata)
  );

  // Synchronous RAMs: registered read of the old contents, byte-lane writes.
  logic [31:0] mem_rr [0:4095];
  logic [31:0] mem_fx [0:4095];

  always @(posedge clk) begin
    if (rr_ram_chipselect) begin
      rr_ram_readdata <= mem_rr[rr_ram_address];
      if (rr_ram_write)
        for (int b = 0; b < 4; b++)
          if (rr_ram_byteenable[b]) mem_rr[rr_ram_address][8*b +: 8] <= rr_ram_writedata[8*b +: 8];
    end
  end

  always @(posedge clk) begin
    if (fx_ram_chipselect) begin
      fx_ram_readdata <= mem_fx[fx_ram_address];
      if (fx_ram_write)
        for (int b = 0; b < 4; b++)
          if (fx_ram_byteenable[b]) mem_fx[fx_ram_address][8*b +: 8] <= fx_ram_writedata[8*b +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  // Presents one m0 command for exactly one cycle, starting just after a rising edge.
  task automatic drive0(input logic rd, input logic wr, input logic [11:0] a,
                        input logic [3:0] be, input logic [31:0] d);
    @(posedge clk); #1;
    m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
  endtask

  logic       g0, g1, prev_v, prev_o, done;
  logic [31:0] prev_d;
  int k, i0, i1, nstrobe, first_s, last_s, first_g;

  initial begin
    reset = 1'b1;
    m0_address = '0; m1_address = '0; m0_byteenable = '0; m1_byteenable = '0;
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    m0_writedata = '0; m1_writedata = '0;

    // Reset state, with both requesters asking.
    @(posedge clk); #1;
    m0_read = 1; m1_read = 1;
    @(negedge clk);
    check("rst_cs", 32'(rr_ram_chipselect), 0);
    check("rst_wr", 32'(rr_ram_write), 0);
    check("rst_rdv", {30'd0, rr_m0_readdatavalid, rr_m1_readdatavalid}, 0);
    check("rst_clken", 32'(rr_ram_clken), 1);
    check("rst_rstreq", 32'(rr_ram_reset_req), 0);
    @(posedge clk); #1;
    reset = 0; m0_read = 0; m1_read = 0;

    // Single-requester write then read.
    drive0(0, 1, 12'h123, 4'hF, 32'hDEADBEEF);
    @(negedge clk);
    check("w_wait", 32'(rr_m0_waitrequest), 0);
    check("w_cs", 32'(rr_ram_chipselect), 1);
    check("w_ramwr", 32'(rr_ram_write), 1);
    check("w_addr", 32'(rr_ram_address), 32'h123);
    drive0(1, 0, 12'h123, 4'hF, 32'h0);
    @(negedge clk);
    check("r_wait", 32'(rr_m0_waitrequest), 0);
    check("r_ramwr", 32'(rr_ram_write), 0);
    check("w_norv", 32'(rr_m0_readdatavalid), 0);
    drive0(0, 0, 12'h0, 4'h0, 32'h0);
    @(negedge clk);
    check("r_rdv0", 32'(rr_m0_readdatavalid), 1);
    check("r_data", rr_m0_readdata, 32'hDEADBEEF);
    check("r_rdv1", 32'(rr_m1_readdatavalid), 0);
    @(negedge clk);
    check("r_once", 32'(rr_m0_readdatavalid), 0);

    // Byte lanes.
    drive0(0, 1, 12'h050, 4'hF, 32'h00000000);
    drive0(0, 1, 12'h050, 4'h5, 32'hAABBCCDD);
    drive0(1, 0, 12'h050, 4'hF, 32'h0);
    drive0(0, 0, 12'h0, 4'h0, 32'h0);
    @(negedge clk);
    check("be_rdv", 32'(rr_m0_readdatavalid), 1);
    check("be_data", rr_m0_readdata, 32'h00BB00DD);

    // Read+write together is a write.
    drive0(1, 1, 12'h010, 4'hF, 32'h5A5A5A5A);
    @(negedge clk);
    check("rw_ramwr", 32'(rr_ram_write), 1);
    check("rw_wdata", rr_ram_writedata, 32'h5A5A5A5A);
    drive0(1, 0, 12'h010, 4'hF, 32'h0);
    @(negedge clk);
    check("rw_norv", {30'd0, rr_m0_readdatavalid, rr_m1_readdatavalid}, 0);
    drive0(0, 0, 12'h0, 4'h0, 32'h0);
    @(negedge clk);
    check("rw_data", rr_m0_readdata, 32'h5A5A5A5A);

    // Preload words for the contention test.
    for (int i = 0; i < 16; i++) drive0(0, 1, 12'(12'h200 + i), 4'hF, pat(i));
    drive0(0, 0, 12'h0, 4'h0, 32'h0);

    // Reset mid-read: m1 read granted in N, reset in N+1.
    @(posedge clk); #1;
    m1_read = 1; m1_address = 12'h123;
    @(negedge clk);
    check("mr_grant", 32'(rr_m1_waitrequest), 0);
    @(posedge clk); #1;
    reset = 1; m0_read = 1; m0_address = 12'h200;
    @(negedge clk);
    check("mr_rdv1", 32'(rr_m1_readdatavalid), 0);
    check("mr_cs", 32'(rr_ram_chipselect), 0);
    @(posedge clk); #1;
    m0_address = 12'h200; m1_address = 12'h208;
    @(negedge clk);
    check("mr_cs2", 32'(rr_ram_chipselect), 0);

    // Round-robin contention, requests held from the cycle after reset.
    @(posedge clk); #1;
    reset = 0;
    i0 = 0; i1 = 0; k = 0; nstrobe = 0; first_s = -1; last_s = -1; first_g = -1;
    prev_v = 0; prev_o = 0; prev_d = '0; done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      check("rr_rdv0", 32'(rr_m0_readdatavalid), 32'(prev_v && !prev_o));
      check("rr_rdv1", 32'(rr_m1_readdatavalid), 32'(prev_v && prev_o));
      if (prev_v) begin
        check("rr_data", prev_o ? rr_m1_readdata : rr_m0_readdata, prev_d);
        check("rr_other", prev_o ? rr_m0_readdata : rr_m1_readdata, 32'h0);
        nstrobe++;
        if (first_s < 0) first_s = c;
        last_s = c;
      end
      if (!m0_read && !m1_read) begin
        done = 1;
        break;
      end
      g0 = m0_read && !rr_m0_waitrequest;
      g1 = m1_read && !rr_m1_waitrequest;
      check("rr_onegrant", 32'(g0) + 32'(g1), 1);
      check("rr_owner", 32'(g1), 32'(k % 2));
      if (first_g < 0 && (g0 || g1)) first_g = c;
      prev_v = g0 | g1;
      prev_o = g1;
      prev_d = g1 ? pat(8 + i1) : pat(i0);
      if (g0 || g1) k++;
      @(posedge clk); #1;
      if (g0) begin
        i0++;
        if (i0 == 8) m0_read = 0; else m0_address = 12'(12'h200 + i0);
      end
      if (g1) begin
        i1++;
        if (i1 == 8) m1_read = 0; else m1_address = 12'(12'h208 + i1);
      end
    end
    check("rr_done", 32'(done), 1);
    check("rr_strobes", 32'(nstrobe), 16);
    check("rr_first", 32'(first_s - first_g), 1);
    check("rr_span", 32'(last_s - first_s), 15);

    // Fixed priority with starvation limit 4 on the second instance.
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0; m0_read = 1; m0_address = 12'h200; m1_read = 1; m1_address = 12'h20F;
    done = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check("fx_starve", 32'(u_fx.starve_cnt), 32'(c - 1));
      check("fx_m1wait", 32'(fx_m1_waitrequest), 32'(c < 5));
      check("fx_m0wait", 32'(fx_m0_waitrequest), 32'(c == 5));
      if (!fx_m1_waitrequest) begin
        done = 1;
        break;
      end
    end
    check("fx_granted", 32'(done), 1);
    @(posedge clk); #1;
    m1_read = 0;
    @(negedge clk);
    check("fx_m0resume", 32'(fx_m0_waitrequest), 0);
    check("fx_starve0", 32'(u_fx.starve_cnt), 0);
    check("fx_m1rdv", 32'(fx_m1_readdatavalid), 1);
    check("fx_m1data", fx_m1_readdata, pat(15));
    @(posedge clk); #1;
    m0_read = 0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
